// File: rtl/slot_pkg.sv
// Shared types and default constants for the slot reel spinner.
package slot_pkg;

  localparam int unsigned SYM_W        = 4;
  localparam int unsigned NUM_SYM_DEF  = 10;
  localparam int unsigned TICK_DIV_DEF = 4;
  localparam int unsigned STEP1_DEF    = 1;
  localparam int unsigned STEP2_DEF    = 3;
  localparam int unsigned STEP3_DEF    = 7;

  // Encoding name counts how many reels are still spinning.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPIN3 = 3'd1,
    SPIN2 = 3'd2,
    SPIN1 = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/slot_reel.sv
// One reel: symbol register that advances by STEP modulo NUM_SYM when adv is high.
module slot_reel
  import slot_pkg::*;
#(
  parameter int unsigned NUM_SYM = NUM_SYM_DEF,
  parameter int unsigned STEP    = STEP1_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [SYM_W-1:0] sym
);

  localparam int unsigned SUM_W = SYM_W + 1;

  logic [SUM_W-1:0] sum;

  // Sum needs one extra bit: sym + STEP can reach 2*NUM_SYM-2.
  assign sum = {1'b0, sym} + SUM_W'(STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym <= '0;
    end else if (adv) begin
      sym <= SYM_W'((sum >= SUM_W'(NUM_SYM)) ? sum - SUM_W'(NUM_SYM) : sum);
    end
  end

endmodule

// File: rtl/slot_reel_spinner.sv
// Three-reel spinner: prescaled reel advance, button edge detect, stop-sequencing FSM
// and registered win compare feeding the win/lose display.
module slot_reel_spinner
  import slot_pkg::*;
#(
  parameter int unsigned NUM_SYM  = NUM_SYM_DEF,
  parameter int unsigned TICK_DIV = TICK_DIV_DEF,
  parameter int unsigned STEP1    = STEP1_DEF,
  parameter int unsigned STEP2    = STEP2_DEF,
  parameter int unsigned STEP3    = STEP3_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  output logic [SYM_W-1:0] reel1,
  output logic [SYM_W-1:0] reel2,
  output logic [SYM_W-1:0] reel3,
  output logic [2:0]       spinning,
  output logic             result_valid,
  output logic             win
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t           state;
  logic             start_prev;
  logic             stop_prev;
  logic [CNT_W-1:0] cnt;
  logic             start_edge;
  logic             stop_edge;
  logic             accept;
  logic             tick;
  logic [2:0]       frz;
  logic [2:0]       adv;

  assign start_edge = start & ~start_prev;
  assign stop_edge  = stop & ~stop_prev;
  assign accept     = start_edge && ((state == IDLE) || (state == DONE));
  assign tick       = (cnt == CNT_W'(TICK_DIV - 1));

  // Reel being frozen this cycle must not take a coincident tick.
  always_comb begin
    frz = 3'b000;
    if (stop_edge) begin
      case (state)
        SPIN3:   frz = 3'b001;
        SPIN2:   frz = 3'b010;
        SPIN1:   frz = 3'b100;
        default: frz = 3'b000;
      endcase
    end
  end

  assign adv = spinning & ~frz & {3{tick}};

  // Prescaler restarts on an accepted start so the first tick lands TICK_DIV clocks later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      start_prev   <= 1'b0;
      stop_prev    <= 1'b0;
      spinning     <= 3'b000;
      result_valid <= 1'b0;
      win          <= 1'b0;
    end else begin
      start_prev <= start;
      stop_prev  <= stop;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state        <= SPIN3;
            spinning     <= 3'b111;
            result_valid <= 1'b0;
            win          <= 1'b0;
          end
        end
        SPIN3: begin
          if (stop_edge) begin
            state    <= SPIN2;
            spinning <= 3'b110;
          end
        end
        SPIN2: begin
          if (stop_edge) begin
            state    <= SPIN1;
            spinning <= 3'b100;
          end
        end
        SPIN1: begin
          if (stop_edge) begin
            state        <= DONE;
            spinning     <= 3'b000;
            result_valid <= 1'b1;
            win          <= (reel1 == reel2) && (reel2 == reel3);
          end
        end
        default: begin
          state    <= IDLE;
          spinning <= 3'b000;
        end
      endcase
    end
  end

  slot_reel #(.NUM_SYM(NUM_SYM), .STEP(STEP1)) u_reel1 (
    .clk (clk), .rst (rst), .adv (adv[0]), .sym (reel1)
  );

  slot_reel #(.NUM_SYM(NUM_SYM), .STEP(STEP2)) u_reel2 (
    .clk (clk), .rst (rst), .adv (adv[1]), .sym (reel2)
  );

  slot_reel #(.NUM_SYM(NUM_SYM), .STEP(STEP3)) u_reel3 (
    .clk (clk), .rst (rst), .adv (adv[2]), .sym (reel3)
  );

endmodule
